// File: rtl/raster_traverser.sv
`default_nettype none
// ============================================================================
//  Module   : raster_traverser
//  Brief    : Bounding-box walker. Accepts one set-up triangle, walks its
//             bbox in raster order updating edge and Z values with adds
//             only, and emits one pixel record per accepted beat.
//  Options  : RASTER_TRAV_CULL_EN - drop candidates with any negative edge
//             value, using a one-record lookahead so pix_last stays exact.
//  Revision : 1.0 - initial release
// ============================================================================
module raster_traverser #(
    parameter int COORD_W = 16,
    parameter int EDGE_W  = 32,
    parameter int STEP_W  = 16,
    parameter int Z_W     = 32,
    parameter int META_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_vld,
    output logic               tri_rdy,
    input  logic [COORD_W-1:0] tri_min_x,
    input  logic [COORD_W-1:0] tri_min_y,
    input  logic [COORD_W-1:0] tri_max_x,
    input  logic [COORD_W-1:0] tri_max_y,
    input  logic [EDGE_W-1:0]  tri_e0,
    input  logic [EDGE_W-1:0]  tri_e1,
    input  logic [EDGE_W-1:0]  tri_e2,
    input  logic [STEP_W-1:0]  tri_dedx0,
    input  logic [STEP_W-1:0]  tri_dedx1,
    input  logic [STEP_W-1:0]  tri_dedx2,
    input  logic [STEP_W-1:0]  tri_dedy0,
    input  logic [STEP_W-1:0]  tri_dedy1,
    input  logic [STEP_W-1:0]  tri_dedy2,
    input  logic [Z_W-1:0]     tri_z,
    input  logic [STEP_W-1:0]  tri_dzdx,
    input  logic [STEP_W-1:0]  tri_dzdy,
    input  logic [META_W-1:0]  tri_meta,
    output logic               pix_vld,
    input  logic               pix_rdy,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [EDGE_W-1:0]  pix_e0,
    output logic [EDGE_W-1:0]  pix_e1,
    output logic [EDGE_W-1:0]  pix_e2,
    output logic [Z_W-1:0]     pix_z,
    output logic [STEP_W-1:0]  pix_dzdx,
    output logic [STEP_W-1:0]  pix_dzdy,
    output logic [META_W-1:0]  pix_meta,
    output logic               pix_last,
    output logic               tri_done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    // Triangle inputs regrouped as arrays so the per-edge math is one loop
    logic [EDGE_W-1:0] w_tri_e    [3];
    logic [STEP_W-1:0] w_tri_dedx [3];
    logic [STEP_W-1:0] w_tri_dedy [3];

    assign w_tri_e[0]    = tri_e0;
    assign w_tri_e[1]    = tri_e1;
    assign w_tri_e[2]    = tri_e2;
    assign w_tri_dedx[0] = tri_dedx0;
    assign w_tri_dedx[1] = tri_dedx1;
    assign w_tri_dedx[2] = tri_dedx2;
    assign w_tri_dedy[0] = tri_dedy0;
    assign w_tri_dedy[1] = tri_dedy1;
    assign w_tri_dedy[2] = tri_dedy2;

    // Latched triangle constants
    logic [COORD_W-1:0] r_min_x, r_max_x, r_max_y;
    logic [STEP_W-1:0]  r_dedx [3];
    logic [STEP_W-1:0]  r_dedy [3];
    logic [STEP_W-1:0]  r_dzdx, r_dzdy;
    logic [META_W-1:0]  r_meta;

    // Walker: current candidate plus row-start accumulators
    logic [COORD_W-1:0] r_cx, r_cy;
    logic [EDGE_W-1:0]  r_ce [3];
    logic [EDGE_W-1:0]  r_re [3];
    logic [Z_W-1:0]     r_cz, r_rz;
    logic               r_walk;

    logic w_accept, w_bbox_ok, w_x_more, w_y_more, w_cand_end;
    logic w_walk_adv, w_scan_end;

    function automatic logic [EDGE_W-1:0] sext_e(input logic [STEP_W-1:0] d);
        return {{(EDGE_W-STEP_W){d[STEP_W-1]}}, d};
    endfunction

    function automatic logic [Z_W-1:0] sext_z(input logic [STEP_W-1:0] d);
        return {{(Z_W-STEP_W){d[STEP_W-1]}}, d};
    endfunction

    assign w_accept   = (r_state == c_ST_IDLE) && tri_vld;
    assign w_bbox_ok  = (tri_max_x >= tri_min_x) && (tri_max_y >= tri_min_y);
    // Strict compares: x/y are only incremented while below max, so 65535 never wraps
    assign w_x_more   = r_cx < r_max_x;
    assign w_y_more   = r_cy < r_max_y;
    assign w_cand_end = !w_x_more && !w_y_more;

    assign tri_rdy  = (r_state == c_ST_IDLE);
    assign tri_done = (r_state == c_ST_DONE);
    assign pix_dzdx = r_dzdx;
    assign pix_dzdy = r_dzdy;
    assign pix_meta = r_meta;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (tri_vld)    w_state_nxt = w_bbox_ok ? c_ST_SCAN : c_ST_DONE;
            c_ST_SCAN: if (w_scan_end) w_state_nxt = c_ST_DONE;
            c_ST_DONE:                 w_state_nxt = c_ST_IDLE;
            default:                   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Capture the per-triangle constants on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_x <= '0;
            r_max_x <= '0;
            r_max_y <= '0;
            r_dzdx  <= '0;
            r_dzdy  <= '0;
            r_meta  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dedx[i] <= '0;
                r_dedy[i] <= '0;
            end
        end else if (w_accept) begin
            r_min_x <= tri_min_x;
            r_max_x <= tri_max_x;
            r_max_y <= tri_max_y;
            r_dzdx  <= tri_dzdx;
            r_dzdy  <= tri_dzdy;
            r_meta  <= tri_meta;
            for (int i = 0; i < 3; i++) begin
                r_dedx[i] <= w_tri_dedx[i];
                r_dedy[i] <= w_tri_dedy[i];
            end
        end
    end

    // Raster walker: step x within a row, then restart from the row-start accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_cz   <= '0;
            r_rz   <= '0;
            r_walk <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_ce[i] <= '0;
                r_re[i] <= '0;
            end
        end else if (w_accept) begin
            r_cx   <= tri_min_x;
            r_cy   <= tri_min_y;
            r_cz   <= tri_z;
            r_rz   <= tri_z;
            r_walk <= w_bbox_ok;
            for (int i = 0; i < 3; i++) begin
                r_ce[i] <= w_tri_e[i];
                r_re[i] <= w_tri_e[i];
            end
        end else if (w_walk_adv) begin
            if (w_x_more) begin
                r_cx <= r_cx + COORD_W'(1);
                r_cz <= r_cz + sext_z(r_dzdx);
                for (int i = 0; i < 3; i++) r_ce[i] <= r_ce[i] + sext_e(r_dedx[i]);
            end else if (w_y_more) begin
                r_cx <= r_min_x;
                r_cy <= r_cy + COORD_W'(1);
                r_rz <= r_rz + sext_z(r_dzdy);
                r_cz <= r_rz + sext_z(r_dzdy);
                for (int i = 0; i < 3; i++) begin
                    r_re[i] <= r_re[i] + sext_e(r_dedy[i]);
                    r_ce[i] <= r_re[i] + sext_e(r_dedy[i]);
                end
            end else begin
                r_walk <= 1'b0;
            end
        end
    end

`ifdef RASTER_TRAV_CULL_EN
    // Stage holds one inside pixel until we know whether another follows it
    logic [COORD_W-1:0] r_sx, r_sy, r_ox, r_oy;
    logic [EDGE_W-1:0]  r_se [3];
    logic [EDGE_W-1:0]  r_oe [3];
    logic [Z_W-1:0]     r_sz, r_oz;
    logic               r_s_vld, r_o_vld, r_o_last;
    logic               w_out_free, w_cand_in, w_s_move, w_s_free;

    assign w_out_free = !r_o_vld || pix_rdy;
    assign w_cand_in  = r_walk && !r_ce[0][EDGE_W-1] && !r_ce[1][EDGE_W-1]
                        && !r_ce[2][EDGE_W-1];
    // Stage resolves once the next inside pixel appears or the walk is exhausted
    assign w_s_move   = r_s_vld && (w_cand_in || !r_walk) && w_out_free;
    assign w_s_free   = !r_s_vld || w_s_move;
    assign w_walk_adv = r_walk && (!w_cand_in || w_s_free);
    assign w_scan_end = !r_walk && !r_s_vld && w_out_free;

    // Lookahead stage and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sx     <= '0;
            r_sy     <= '0;
            r_sz     <= '0;
            r_s_vld  <= 1'b0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_oz     <= '0;
            r_o_vld  <= 1'b0;
            r_o_last <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_se[i] <= '0;
                r_oe[i] <= '0;
            end
        end else begin
            if (w_cand_in && w_s_free) begin
                r_sx    <= r_cx;
                r_sy    <= r_cy;
                r_sz    <= r_cz;
                r_s_vld <= 1'b1;
                for (int i = 0; i < 3; i++) r_se[i] <= r_ce[i];
            end else if (w_s_move) begin
                r_s_vld <= 1'b0;
            end
            if (w_s_move) begin
                r_ox     <= r_sx;
                r_oy     <= r_sy;
                r_oz     <= r_sz;
                r_o_vld  <= 1'b1;
                r_o_last <= !r_walk;
                for (int i = 0; i < 3; i++) r_oe[i] <= r_se[i];
            end else if (w_out_free) begin
                r_o_vld  <= 1'b0;
                r_o_last <= 1'b0;
            end
        end
    end

    assign pix_vld  = r_o_vld;
    assign pix_last = r_o_last;
    assign pix_x    = r_ox;
    assign pix_y    = r_oy;
    assign pix_e0   = r_oe[0];
    assign pix_e1   = r_oe[1];
    assign pix_e2   = r_oe[2];
    assign pix_z    = r_oz;
`else
    // Every candidate is presented directly from the walker registers
    assign w_walk_adv = r_walk && pix_rdy;
    assign w_scan_end = r_walk && w_cand_end && pix_rdy;

    assign pix_vld  = r_walk;
    assign pix_last = r_walk && w_cand_end;
    assign pix_x    = r_cx;
    assign pix_y    = r_cy;
    assign pix_e0   = r_ce[0];
    assign pix_e1   = r_ce[1];
    assign pix_e2   = r_ce[2];
    assign pix_z    = r_cz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_raster_traverser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raster_traverser
//  Brief    : Directed self-checking bench for raster_traverser.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raster_traverser;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_vld;
    logic        tri_rdy;
    logic [15:0] tri_min_x, tri_min_y, tri_max_x, tri_max_y;
    logic [31:0] tri_e0, tri_e1, tri_e2;
    logic [15:0] tri_dedx0, tri_dedx1, tri_dedx2;
    logic [15:0] tri_dedy0, tri_dedy1, tri_dedy2;
    logic [31:0] tri_z;
    logic [15:0] tri_dzdx, tri_dzdy;
    logic [15:0] tri_meta;
    logic        pix_vld;
    logic        pix_rdy;
    logic [15:0] pix_x, pix_y;
    logic [31:0] pix_e0, pix_e1, pix_e2;
    logic [31:0] pix_z;
    logic [15:0] pix_dzdx, pix_dzdy;
    logic [15:0] pix_meta;
    logic        pix_last;
    logic        tri_done;

    int checks = 0;
    int errors = 0;

`ifdef RASTER_TRAV_CULL_EN
    localparam int WAIT_MAX = 16;
`else
    localparam int WAIT_MAX = 0;
`endif

    always #5 clk = ~clk;

    raster_traverser dut (
        .clk(clk), .rst(rst),
        .tri_vld(tri_vld), .tri_rdy(tri_rdy),
        .tri_min_x(tri_min_x), .tri_min_y(tri_min_y),
        .tri_max_x(tri_max_x), .tri_max_y(tri_max_y),
        .tri_e0(tri_e0), .tri_e1(tri_e1), .tri_e2(tri_e2),
        .tri_dedx0(tri_dedx0), .tri_dedx1(tri_dedx1), .tri_dedx2(tri_dedx2),
        .tri_dedy0(tri_dedy0), .tri_dedy1(tri_dedy1), .tri_dedy2(tri_dedy2),
        .tri_z(tri_z), .tri_dzdx(tri_dzdx), .tri_dzdy(tri_dzdy),
        .tri_meta(tri_meta),
        .pix_vld(pix_vld), .pix_rdy(pix_rdy),
        .pix_x(pix_x), .pix_y(pix_y),
        .pix_e0(pix_e0), .pix_e1(pix_e1), .pix_e2(pix_e2),
        .pix_z(pix_z), .pix_dzdx(pix_dzdx), .pix_dzdy(pix_dzdy),
        .pix_meta(pix_meta), .pix_last(pix_last), .tri_done(tri_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_edges(input int e0, dx0, dy0, e1, dx1, dy1, e2, dx2, dy2,
                             input int z, dzx, dzy);
        tri_e0 = 32'(e0); tri_dedx0 = 16'(dx0); tri_dedy0 = 16'(dy0);
        tri_e1 = 32'(e1); tri_dedx1 = 16'(dx1); tri_dedy1 = 16'(dy1);
        tri_e2 = 32'(e2); tri_dedx2 = 16'(dx2); tri_dedy2 = 16'(dy2);
        tri_z  = 32'(z);  tri_dzdx  = 16'(dzx); tri_dzdy  = 16'(dzy);
    endtask

    task automatic send(input int minx, miny, maxx, maxy);
        chk("tri_rdy_before_send", 32'(tri_rdy), 1);
        tri_min_x = 16'(minx); tri_min_y = 16'(miny);
        tri_max_x = 16'(maxx); tri_max_y = 16'(maxy);
        tri_vld = 1'b1;
        step();
        tri_vld = 1'b0;
    endtask

    task automatic check_rec(input string tag, input int x, y, e0, e1, e2, z, input bit last);
        chk({tag, "_vld"},  32'(pix_vld),  1);
        chk({tag, "_x"},    32'(pix_x),    32'(x));
        chk({tag, "_y"},    32'(pix_y),    32'(y));
        chk({tag, "_e0"},   pix_e0,        32'(e0));
        chk({tag, "_e1"},   pix_e1,        32'(e1));
        chk({tag, "_e2"},   pix_e2,        32'(e2));
        chk({tag, "_z"},    pix_z,         32'(z));
        chk({tag, "_last"}, 32'(pix_last), 32'(last));
    endtask

    // Wait (bounded) for a record, check it, hold it through nstall stalls, then accept it
    task automatic expect_pix(input string tag, input int x, y, e0, e1, e2, z,
                              input bit last, input int nstall);
        int n = 0;
        pix_rdy = 1'b1;
        while (!pix_vld && n < WAIT_MAX) begin
            step();
            n++;
        end
        check_rec(tag, x, y, e0, e1, e2, z, last);
        for (int s = 0; s < nstall; s++) begin
            pix_rdy = 1'b0;
            step();
            check_rec($sformatf("%s_stall%0d", tag, s), x, y, e0, e1, e2, z, last);
        end
        pix_rdy = 1'b1;
        step();
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done_pulse"}, 32'(tri_done), 1);
        chk({tag, "_vld_low"},    32'(pix_vld),  0);
        chk({tag, "_rdy_low"},    32'(tri_rdy),  0);
        step();
        chk({tag, "_done_clear"}, 32'(tri_done), 0);
        chk({tag, "_rdy_back"},   32'(tri_rdy),  1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int xs [6]  = '{2, 3, 4, 2, 3, 4};
        int ys [6]  = '{3, 3, 3, 4, 4, 4};
        int e0s [6] = '{10, 8, 6, 15, 13, 11};
        int e1s [6] = '{-7, -4, -1, -8, -5, -2};
        int e2s [6] = '{0, -32768, -65536, 32767, -1, -32769};
        int zs [6]  = '{100, 101, 102, 96, 97, 98};
        int seen;
        bit got_done;

        rst = 1'b1; tri_vld = 1'b0; pix_rdy = 1'b1; tri_meta = 16'h0000;
        tri_min_x = '0; tri_min_y = '0; tri_max_x = '0; tri_max_y = '0;
        set_edges(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_tri_rdy",  32'(tri_rdy),  1);
        chk("reset_pix_vld",  32'(pix_vld),  0);
        chk("reset_pix_last", 32'(pix_last), 0);
        chk("reset_tri_done", 32'(tri_done), 0);
        chk("reset_pix_x",    32'(pix_x),    0);
        chk("reset_pix_e0",   pix_e0,        0);
        chk("reset_pix_z",    pix_z,         0);
        rst = 1'b0;
        step();

`ifndef RASTER_TRAV_CULL_EN
        // 3x2 walk, full throughput
        tri_meta = 16'hBEEF;
        set_edges(10, -2, 5, -7, 3, -1, 0, -32768, 32767, 100, 1, -4);
        send(2, 3, 4, 4);
        chk("t1_dzdx", 32'(pix_dzdx), 32'h0001);
        chk("t1_dzdy", 32'(pix_dzdy), 32'hFFFC);
        chk("t1_meta", 32'(pix_meta), 32'hBEEF);
        for (int k = 0; k < 6; k++)
            expect_pix($sformatf("t1_p%0d", k), xs[k], ys[k], e0s[k], e1s[k], e2s[k], zs[k],
                       k == 5, 0);
        expect_done("t1");

        // Same triangle with back-pressure 1,0,0,1,0,0,...
        send(2, 3, 4, 4);
        for (int k = 0; k < 6; k++)
            expect_pix($sformatf("t2_p%0d", k), xs[k], ys[k], e0s[k], e1s[k], e2s[k], zs[k],
                       k == 5, (k == 0) ? 0 : 2);
        expect_done("t2");

        // Single pixel
        set_edges(5, 1, 1, 6, 1, 1, 7, 1, 1, 8, 1, 1);
        send(7, 7, 7, 7);
        expect_pix("t3_single", 7, 7, 5, 6, 7, 8, 1'b1, 0);
        expect_done("t3");

        // Top-of-range x bounds
        set_edges(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(65534, 0, 65535, 0);
        expect_pix("t4_p0", 65534, 0, 0, 0, 0, 0, 1'b0, 0);
        expect_pix("t4_p1", 65535, 0, 1, 0, 0, 0, 1'b1, 0);
        expect_done("t4");
`else
        // Only (2,0) and (3,0) have all edges non-negative
        set_edges(-3, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        send(0, 0, 3, 0);
        expect_pix("c1_p0", 2, 0, 1, 1, 1, 0, 1'b0, 0);
        expect_pix("c1_p1", 3, 0, 3, 1, 1, 0, 1'b1, 0);
        expect_done("c1");

        // Fully outside: no records, done still pulses
        set_edges(-1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        send(0, 0, 1, 0);
        seen = 0;
        got_done = 1'b0;
        for (int n = 0; n < 20 && !got_done; n++) begin
            if (pix_vld) seen++;
            if (tri_done) got_done = 1'b1;
            else step();
        end
        chk("c2_no_records", 32'(seen), 0);
        chk("c2_done_seen",  32'(got_done), 1);
        step();
        chk("c2_rdy_back",   32'(tri_rdy), 1);
`endif

        // Degenerate bbox: min_x > max_x
        set_edges(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        send(5, 0, 4, 0);
        chk("t5_vld_low",    32'(pix_vld),  0);
        chk("t5_done_pulse", 32'(tri_done), 1);
        step();
        chk("t5_vld_low2",   32'(pix_vld),  0);
        chk("t5_done_clear", 32'(tri_done), 0);
        chk("t5_rdy_back",   32'(tri_rdy),  1);

        // Reset in the middle of a 3x3 walk
        set_edges(0, 1, 10, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        send(0, 0, 2, 2);
        expect_pix("t6_p0", 0, 0, 0, 1, 1, 0, 1'b0, 0);
        expect_pix("t6_p1", 1, 0, 1, 1, 1, 0, 1'b0, 0);
        pix_rdy = 1'b0;
        begin
            int n = 0;
            while (!pix_vld && n < WAIT_MAX) begin
                step();
                n++;
            end
        end
        chk("t6_p2_x", 32'(pix_x), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pix_rdy = 1'b1;
        chk("t6_rst_vld",  32'(pix_vld),  0);
        chk("t6_rst_rdy",  32'(tri_rdy),  1);
        chk("t6_rst_last", 32'(pix_last), 0);
        chk("t6_rst_done", 32'(tri_done), 0);
        step();
        chk("t6_no_resume", 32'(pix_vld), 0);

        // Normal acceptance after the reset
        set_edges(4, 0, 0, 4, 0, 0, 4, 0, 0, 9, 0, 0);
        send(7, 7, 7, 7);
        expect_pix("t7_single", 7, 7, 4, 4, 4, 9, 1'b1, 0);
        expect_done("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raster_traverser.md
Name: raster_traverser

Overview:
- Bounding-box walker that feeds the pixel processor's per-pixel vld/rdy input.
- Accepts one set-up triangle from triangle setup: bbox, edge values at the bbox min corner, per-edge x/y step deltas, Z plane, metadata.
- Walks the bbox in raster order, updating edge and Z values incrementally with adds only. Emits one pixel record per accepted beat.

Parameters:
- COORD_W, 16, unsigned screen coordinate width.
- EDGE_W, 32, signed edge-function width (2x fixed-point total bits).
- STEP_W, 16, signed per-step delta width for edges and Z (fixed-point total bits).
- Z_W, 32, Z accumulator width (2x fixed-point total bits).
- META_W, 16, opaque metadata width, passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tri_vld  in  1  triangle setup valid
- tri_rdy  out  1  traverser can accept a triangle
- tri_min_x, tri_min_y, tri_max_x, tri_max_y  in  COORD_W each  inclusive bbox
- tri_e0, tri_e1, tri_e2  in  EDGE_W each  signed edge values at (min_x, min_y)
- tri_dedx0..2  in  STEP_W each  signed edge delta per +1 x
- tri_dedy0..2  in  STEP_W each  signed edge delta per +1 y
- tri_z  in  Z_W  Z at (min_x, min_y)
- tri_dzdx, tri_dzdy  in  STEP_W each  signed Z deltas
- tri_meta  in  META_W  metadata
- pix_vld  out  1  pixel record valid
- pix_rdy  in  1  pixel processor ready
- pix_x, pix_y  out  COORD_W each  pixel coordinate
- pix_e0, pix_e1, pix_e2  out  EDGE_W each  edge values at pixel
- pix_z  out  Z_W  interpolated Z
- pix_dzdx, pix_dzdy  out  STEP_W each  registered copies of triangle deltas
- pix_meta  out  META_W  registered metadata
- pix_last  out  1  final record of the triangle
- tri_done  out  1  one-cycle pulse when a triangle completes

Behaviour:
- Reset (rst=1 at clk edge):
  - State IDLE; tri_rdy=1 after reset; pix_vld=0; pix_last=0; tri_done=0.
  - All datapath registers cleared to 0.
  - Applies mid-triangle: the in-flight triangle is dropped, no further pixels.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - tri_rdy=1.
  - On tri_vld&&tri_rdy: latch all tri_* inputs. Load row-start and current edge/Z accumulators, x=min_x, y=min_y.
  - Bbox valid (max_x>=min_x and max_y>=min_y): go SCAN.
  - Degenerate bbox: go DONE with no pixels.
- SCAN:
  - tri_rdy=0.
  - Output register holds one record. Record advances when !pix_vld || pix_rdy.
  - First pix_vld is asserted the cycle after triangle acceptance (latency 1).
  - While pix_vld && !pix_rdy: all pix_* outputs are held stable.
  - Step rule, on advance:
    - If x<max_x: x+=1; e_i+=sext(dedx_i); z+=sext(dzdx).
    - Else if y<max_y: x=min_x; y+=1; row_e_i+=sext(dedy_i); e_i=new row_e_i; row_z+=sext(dzdy); z=new row_z.
    - Else: the current record is the last one.
  - pix_last=1 on the record at (max_x, max_y).
  - When the last record is accepted (pix_vld&&pix_rdy&&pix_last): go DONE, pix_vld=0.
  - Sustained throughput: 1 pixel/clk with pix_rdy held high.
- DONE:
  - Single cycle; tri_done=1; go IDLE. tri_rdy reasserts the following cycle.
- Arithmetic:
  - Two's-complement wrapping adds at EDGE_W / Z_W.
  - Deltas are sign-extended from STEP_W.
  - No saturation; coordinates never exceed max, so no coordinate wrap.
- Single-pixel bbox: exactly one record, with pix_last=1.
- Coordinate 0 and all-ones (65535) bounds must be handled without overflow of the x/y compare.

Optional Feature:
- Macro: RASTER_TRAV_CULL_EN.
- Defined:
  - A candidate pixel with any of e0/e1/e2 negative (sign bit set) is not presented; the walker steps to the next candidate, one candidate per clk.
  - pix_last marks the last emitted inside pixel.
  - If no pixel is inside, no records are emitted and tri_done still pulses.
  - This requires a one-pixel lookahead so pix_last is correct.
- Undefined:
  - Every bbox pixel is emitted; inside testing is left to the pixel processor.

Test Plan:
- Bbox (2,3)-(4,4); e0=10, dedx0=-2, dedy0=5; pix_rdy=1 -> six records in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4). pix_e0 = 10,8,6,15,13,11. pix_last only on (4,4). tri_done pulses one cycle after that record is accepted.
- Same triangle, pix_rdy toggled 1,0,0,1,... -> outputs stable during stalls, no pixel lost or duplicated. Z with tri_z=100, dzdx=1, dzdy=-4 yields 100,101,102,96,97,98.
- Degenerate bbox min_x=5, max_x=4 -> pix_vld never asserts, tri_done pulses, tri_rdy returns to 1.
- Single pixel (7,7)-(7,7) -> one record at (7,7) with pix_last=1. Bbox at (65534,0)-(65535,0) -> two records, no wrap.
- Assert rst during the 3rd pixel of a 3x3 walk -> pix_vld=0 next cycle, tri_rdy=1. A new triangle is accepted normally.
- RASTER_TRAV_CULL_EN: bbox (0,0)-(3,0), e0=-3, dedx0=2, e1=e2=1, deltas 0 -> only (2,0),(3,0) emitted; (3,0) has pix_last=1.
